mesh_router_p: RTL

Parametrised five-port 2D-mesh router: next generation of the fixed 8-bit router tile. Per-input FIFO buffering, dimension-ordered XY route computation from the flit header, per-output round-robin arbitration, switching through a registered crossbar with valid/ready flow control on every port. Instantiated once per mesh tile; ports connect to the local core and to the four neighbouring routers.

---
 rtl/mesh_router_pkg.sv | 27 ++
 rtl/router_fifo.sv | 53 +++++
 rtl/mesh_router_p.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mesh_router_pkg.sv
// Shared definitions for the five-port XY mesh router: port numbering and
// the dimension-ordered route computation applied to each FIFO head.
package mesh_router_pkg;

    localparam int NUM_PORTS = 5;

    typedef logic [2:0] port_t;

    localparam port_t P_LOCAL = 3'd0;
    localparam port_t P_EAST  = 3'd1;
    localparam port_t P_WEST  = 3'd2;
    localparam port_t P_NORTH = 3'd3;
    localparam port_t P_SOUTH = 3'd4;

    // XY routing: resolve X first, then Y, otherwise deliver to the local core.
    function automatic port_t route_xy(input int unsigned dest_x,
                                       input int unsigned dest_y,
                                       input int unsigned my_x,
                                       input int unsigned my_y);
        if (dest_x > my_x)      return P_EAST;
        else if (dest_x < my_x) return P_WEST;
        else if (dest_y > my_y) return P_NORTH;
        else if (dest_y < my_y) return P_SOUTH;
        else                    return P_LOCAL;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter. Push into a full FIFO is
// refused even if a pop happens on the same edge; the head is registered
// storage only, so a flit pushed into an empty FIFO is visible next cycle.
module router_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write flit storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide
        // which entries are valid, and this lets the array map to plain RAM.
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mesh_router_p.sv
// Five-port 2D-mesh router tile: input FIFOs, XY route compute, per-output
// arbitration and a registered crossbar with valid/ready on every port.
// Build option: define ROUTER_RR_EN for round-robin arbitration per output;
// without it the lowest-numbered requesting input always wins.
module mesh_router_p
    import mesh_router_pkg::*;
#(
    parameter int          DATA_W     = 16,
    parameter int          X_W        = 2,
    parameter int          Y_W        = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned MY_X       = 0,
    parameter int unsigned MY_Y       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_valid,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS-1:0]        out_valid,
    input  logic [NUM_PORTS-1:0]        out_ready
);

    logic [DATA_W-1:0]    head    [NUM_PORTS];
    port_t                route   [NUM_PORTS];
    logic [NUM_PORTS-1:0] req     [NUM_PORTS];  // req[output][input]
    port_t                gnt_idx [NUM_PORTS];
    logic [DATA_W-1:0]    out_reg [NUM_PORTS];
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] free;
    logic [NUM_PORTS-1:0] gnt_any;
    logic [NUM_PORTS-1:0] out_vld;
`ifdef ROUTER_RR_EN
    port_t                rr_ptr  [NUM_PORTS];
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        router_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (in_valid[p]),
            .push_data (in_data[p*DATA_W +: DATA_W]),
            .pop       (pop[p]),
            .full      (full[p]),
            .empty     (empty[p]),
            .head      (head[p])
        );

        assign route[p] = route_xy(32'(head[p][DATA_W-1 -: X_W]),
                                   32'(head[p][DATA_W-X_W-1 -: Y_W]),
                                   MY_X, MY_Y);
        assign out_data[p*DATA_W +: DATA_W] = out_reg[p];
    end

    assign in_ready  = ~full;
    assign free      = ~out_vld | out_ready;
    assign out_valid = out_vld;

    // Each non-empty FIFO head requests exactly the output its route selects.
    always_comb begin
        // NOTE: every comb output gets a default before any conditional write,
        // otherwise untouched bits would hold their value and infer latches.
        for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!empty[p]) req[route[p]][p] = 1'b1;
        end
    end

    // Per-output arbiter: first requester found from the search start wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            gnt_any[o] = 1'b0;
            gnt_idx[o] = P_LOCAL;
            if (free[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef ROUTER_RR_EN
                    idx = (int'(rr_ptr[o]) + k) % NUM_PORTS;
`else
                    idx = k;
`endif
                    if (!gnt_any[o] && req[o][idx]) begin
                        gnt_any[o] = 1'b1;
                        gnt_idx[o] = port_t'(idx);
                    end
                end
            end
        end
    end

    // Pop every input that won an output; an input routes to one output only.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_any[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // Output registers: load the granted head when free, else drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= '0;
            for (int o = 0; o < NUM_PORTS; o++) out_reg[o] <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (free[o]) begin
                    out_vld[o] <= gnt_any[o];
                    if (gnt_any[o]) out_reg[o] <= head[gnt_idx[o]];
                end
            end
        end
    end

`ifdef ROUTER_RR_EN
    // Round-robin pointers move to one past the input just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) rr_ptr[o] <= P_LOCAL;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (free[o] && gnt_any[o]) begin
                    rr_ptr[o] <= (gnt_idx[o] == P_SOUTH) ? P_LOCAL : gnt_idx[o] + 3'd1;
                end
            end
        end
    end
`endif

endmodule
